// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state encoding, block sizes and the
// GF(2^8) helpers that the inverse-cipher datapath modules build on.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int BLK_W  = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    t = ginv(a);
    return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] t;
    t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return ginv(t);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inv_add_round_keys.sv
// AddRoundKey: bitwise XOR of state and round key.
module inv_add_round_keys (
  input  logic [127:0] data_in,
  input  logic [127:0] round_key,
  output logic [127:0] data_out
);

  // Pure XOR, no state.
  assign data_out = data_in ^ round_key;

endmodule

// File: rtl/inv_keygen.sv
// Backward AES-128 key step: from round key round_num derive round key round_num-1.
module inv_keygen
  import aes_pkg::*;
(
  input  logic [3:0]   round_num,
  input  logic [127:0] keyin,
  output logic [127:0] keyout
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] rot_sub;

  assign {w0, w1, w2, w3} = keyin;

  // Words 1..3 of the lower key fall out of neighbouring XORs; word 0 needs
  // SubWord(RotWord()) of the recovered word 3 and the Rcon of round_num.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign rot_sub = {sbox(p3[23:16]), sbox(p3[15:8]), sbox(p3[7:0]), sbox(p3[31:24])};
  assign p0 = w0 ^ rot_sub ^ {rcon(round_num), 24'h000000};
  assign keyout = {p0, p1, p2, p3};

endmodule

// File: rtl/inv_mix_columns.sv
// InvMixColumns: each state column multiplied by the {0e,0b,0d,09} circulant.
module inv_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] data_in,
  output logic [127:0] data_out
);

  // One column (4 bytes) per generate iteration.
  for (genvar c = 0; c < 4; c++) begin : g_col
    localparam int HI = BLK_W - 1 - 32 * c;
    logic [7:0] a0, a1, a2, a3;
    assign a0 = data_in[HI -: 8];
    assign a1 = data_in[HI-8 -: 8];
    assign a2 = data_in[HI-16 -: 8];
    assign a3 = data_in[HI-24 -: 8];
    assign data_out[HI -: 8]    = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    assign data_out[HI-8 -: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    assign data_out[HI-16 -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    assign data_out[HI-24 -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
  end

endmodule

// File: rtl/inv_round.sv
// One full inverse round. keyin is round key round_num; the round consumes and
// emits keyout, the key one round lower, so the caller can chain rounds.
module inv_round (
  input  logic [127:0] in,
  input  logic [127:0] keyin,
  input  logic [3:0]   round_num,
  output logic [127:0] out,
  output logic [127:0] keyout
);

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;

  inv_keygen         u_key   (.round_num(round_num), .keyin(keyin), .keyout(keyout));
  inv_shift_rows     u_shift (.data_in(in), .data_out(shifted));
  inv_subbytes       u_sub   (.data_in(shifted), .data_out(subbed));
  inv_add_round_keys u_ark   (.data_in(subbed), .round_key(keyout), .data_out(keyed));
  inv_mix_columns    u_mix   (.data_in(keyed), .data_out(out));

endmodule

// File: rtl/inv_shift_rows.sv
// InvShiftRows: row r of the column-major state rotates right by r bytes.
module inv_shift_rows
  import aes_pkg::*;
(
  input  logic [127:0] data_in,
  output logic [127:0] data_out
);

  // Byte (r, c) takes the byte from column (c - r) mod 4 of the same row.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC = r + 4 * ((c - r + 4) % 4);
      assign data_out[BLK_W-1-8*(r+4*c) -: 8] = data_in[BLK_W-1-8*SRC -: 8];
    end
  end

endmodule

// File: rtl/inv_subbytes.sv
// InvSubBytes: inverse S-box applied to each of the 16 state bytes.
module inv_subbytes
  import aes_pkg::*;
(
  input  logic [127:0] data_in,
  output logic [127:0] data_out
);

  // Independent byte-wise substitution.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign data_out[BLK_W-1-8*i -: 8] = inv_sbox(data_in[BLK_W-1-8*i -: 8]);
  end

endmodule

// File: rtl/inv_cipher_ctrl.sv
// Iterative AES-128 decryption controller: initial AddRoundKey on accept,
// nine shared inv_round passes, then the final round without InvMixColumns.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Input side: in_ready is high only in IDLE; a source holding in_valid while
// the controller is busy simply waits. Output side: out_valid rises after
// FINAL and stays high with plain_out frozen until out_ready completes it;
// out_ready at any other time is ignored.
module inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain_out,
  output logic         busy
);

  fsm_e         fsm, fsm_d;
  logic [3:0]   rnd;
  logic [127:0] state_q, key_q;
  logic [127:0] round_out, round_key;
  logic [127:0] fin_shift, fin_sub, fin_key, fin_blk;

  // Shared round datapath; round_num names the key currently held in key_q.
  inv_round u_round (
    .in        (state_q),
    .keyin     (key_q),
    .round_num (rnd + 4'd1),
    .out       (round_out),
    .keyout    (round_key)
  );

  // Final round: no InvMixColumns, key K0 derived from K1 in key_q.
  inv_shift_rows     u_fin_shift (.data_in(state_q), .data_out(fin_shift));
  inv_subbytes       u_fin_sub   (.data_in(fin_shift), .data_out(fin_sub));
  inv_keygen         u_fin_key   (.round_num(4'd1), .keyin(key_q), .keyout(fin_key));
  inv_add_round_keys u_fin_ark   (.data_in(fin_sub), .round_key(fin_key), .data_out(fin_blk));

  assign in_ready = (fsm == IDLE);
  assign busy     = (fsm != IDLE);

  // Next-state decode.
  always_comb begin
    fsm_d = fsm;
    case (fsm)
      IDLE:    if (in_valid) fsm_d = ROUND;
      ROUND:   if (rnd == 4'd1) fsm_d = FINAL;
      FINAL:   fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // State register plus datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      rnd       <= 4'd0;
      state_q   <= '0;
      key_q     <= '0;
      plain_out <= '0;
      out_valid <= 1'b0;
    end else begin
      fsm <= fsm_d;
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_q <= cipher_in ^ key_in;
            key_q   <= key_in;
            rnd     <= 4'(NUM_ROUNDS - 1);
          end
        end
        ROUND: begin
          state_q <= round_out;
          key_q   <= round_key;
          rnd     <= rnd - 4'd1;
        end
        FINAL: begin
          plain_out <= fin_blk;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Bench for inv_cipher_ctrl: FIPS-197 vectors, handshake scenarios and random
// blocks checked against a table-driven AES-128 decryption model.
module tb_inv_cipher_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] cipher_in = '0;
  logic [127:0] key_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] plain_out;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   sbox_t[256];
  logic [7:0]   isbox_t[256];
  logic [7:0]   exp_t[256];
  logic [7:0]   log_t[256];
  logic [127:0] exp_q[$];

  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;

  inv_cipher_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cipher_in(cipher_in), .key_in(key_in), .out_valid(out_valid),
    .out_ready(out_ready), .plain_out(plain_out), .busy(busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  // S-box and log/antilog tables from powers of the generator 3.
  task automatic build_tables;
    logic [7:0] p, q, x;
    int k;
    p = 8'h01; q = 8'h01; k = 0;
    exp_t[0] = 8'h01; log_t[1] = 8'h00; log_t[0] = 8'h00;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4) ^ 8'h63;
      sbox_t[p] = x;
      k++;
      if (k < 255) begin
        exp_t[k] = p;
        log_t[p] = 8'(k);
      end
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
  endtask

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    int e;
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    e = (int'(log_t[a]) + int'(log_t[b])) % 255;
    return exp_t[e];
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [127:0] k10);
    logic [7:0]   rk[11][16];
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   rc[11];
    logic [127:0] res;
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int r = 2; r <= 10; r++) rc[r] = mul(rc[r-1], 8'h02);
    for (int i = 0; i < 16; i++) rk[10][i] = k10[127-8*i -: 8];
    for (int r = 10; r >= 1; r--) begin
      for (int i = 4; i < 16; i++) rk[r-1][i] = rk[r][i] ^ rk[r][i-4];
      rk[r-1][0] = rk[r][0] ^ sbox_t[rk[r-1][13]] ^ rc[r];
      rk[r-1][1] = rk[r][1] ^ sbox_t[rk[r-1][14]];
      rk[r-1][2] = rk[r][2] ^ sbox_t[rk[r-1][15]];
      rk[r-1][3] = rk[r][3] ^ sbox_t[rk[r-1][12]];
    end
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rk[10][i];
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row+4*c] = isbox_t[s[row + 4*((c - row + 4) % 4)]] ^ rk[r][row+4*c];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = mul(t[4*c], 8'h0e) ^ mul(t[4*c+1], 8'h0b) ^ mul(t[4*c+2], 8'h0d) ^ mul(t[4*c+3], 8'h09);
          s[4*c+1] = mul(t[4*c], 8'h09) ^ mul(t[4*c+1], 8'h0e) ^ mul(t[4*c+2], 8'h0b) ^ mul(t[4*c+3], 8'h0d);
          s[4*c+2] = mul(t[4*c], 8'h0d) ^ mul(t[4*c+1], 8'h09) ^ mul(t[4*c+2], 8'h0e) ^ mul(t[4*c+3], 8'h0b);
          s[4*c+3] = mul(t[4*c], 8'h0b) ^ mul(t[4*c+1], 8'h0d) ^ mul(t[4*c+2], 8'h09) ^ mul(t[4*c+3], 8'h0e);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a block and hold in_valid until the edge that accepts it.
  task automatic send(input logic [127:0] ct, input logic [127:0] k);
    logic ok;
    cipher_in = ct; key_in = k; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL accept_timeout: in_ready=%0b required 1 within 100 clk", in_ready);
    end
  endtask

  // Clocks counted from the acceptance edge inclusive until out_valid is seen.
  task automatic wait_out(output int cyc);
    logic got;
    cyc = 1; got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (out_valid) got = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL out_valid_timeout: out_valid=%0b required 1 within 60 clk", out_valid);
    end
  endtask

  task automatic take;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Scoreboard check of the current plain_out against the queue head.
  task automatic check_head(input string name);
    logic [127:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_cmp++;
    if (plain_out !== e) begin
      n_err++;
      $display("FAIL %s: plain_out=%h required %h", name, plain_out, e);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    n_cmp++; if (plain_out !== '0) begin n_err++; $display("FAIL reset_plain_out: got %h required 0", plain_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b required 0", busy); end
    rst = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
  endtask

  task automatic test_fips;
    int cyc;
    exp_q.push_back(B_PT);
    send(B_CT, B_KEY);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fips_busy: got %0b required 1", busy); end
    wait_out(cyc);
    n_cmp++; if (cyc != 11) begin n_err++; $display("FAIL fips_b_latency: got %0d clk required 11", cyc); end
    check_head("fips_b_plain");
    take();
    exp_q.push_back(C_PT);
    send(C_CT, C_KEY);
    wait_out(cyc);
    check_head("fips_c1_plain");
    take();
  endtask

  task automatic test_hold;
    int cyc;
    logic [127:0] e;
    logic [127:0] ct, k;
    ct = {$urandom, $urandom, $urandom, $urandom};
    k  = {$urandom, $urandom, $urandom, $urandom};
    e  = ref_decrypt(ct, k);
    send(ct, k);
    wait_out(cyc);
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_out_valid[%0d]: got %0b required 1", i, out_valid); end
      n_cmp++; if (plain_out !== e) begin n_err++; $display("FAIL hold_plain[%0d]: got %h required %h", i, plain_out, e); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready[%0d]: got %0b required 0", i, in_ready); end
      tick();
    end
    take();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %0b required 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL release_out_valid: got %0b required 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL release_busy: got %0b required 0", busy); end
  endtask

  task automatic test_ignore_busy;
    int cyc;
    logic [127:0] a_ct, a_k;
    a_ct = {$urandom, $urandom, $urandom, $urandom};
    a_k  = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(ref_decrypt(a_ct, a_k));
    send(a_ct, a_k);
    tick(); tick(); tick();
    cipher_in = {$urandom, $urandom, $urandom, $urandom};
    key_in    = {$urandom, $urandom, $urandom, $urandom};
    in_valid  = 1'b1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ignore_in_ready: got %0b required 0", in_ready); end
    tick();
    in_valid = 1'b0;
    wait_out(cyc);
    check_head("ignore_plain");
    take();
  endtask

  task automatic test_reset_mid_block;
    int cyc;
    logic seen;
    send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %0b required 0", out_valid); end
    n_cmp++; if (plain_out !== '0) begin n_err++; $display("FAIL midrst_plain: got %h required 0", plain_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %0b required 0", busy); end
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_output: out_valid seen=%0b required 0", seen); end
    exp_q.push_back(B_PT);
    send(B_CT, B_KEY);
    wait_out(cyc);
    check_head("midrst_new_block");
    take();
  endtask

  task automatic test_random;
    int cyc;
    int hold;
    logic [127:0] ct, k;
    for (int n = 0; n < 6; n++) begin
      ct = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(ref_decrypt(ct, k));
      hold = $urandom_range(0, 2);
      for (int i = 0; i < hold; i++) tick();
      send(ct, k);
      wait_out(cyc);
      hold = $urandom_range(0, 3);
      for (int i = 0; i < hold; i++) tick();
      check_head("random_plain");
      take();
    end
  endtask

  task automatic test_back_to_back;
    int t[2];
    logic [127:0] v[2];
    int nout;
    int cyc;
    out_ready = 1'b1;
    send(B_CT, B_KEY);
    cipher_in = C_CT; key_in = C_KEY; in_valid = 1'b1;
    nout = 0; cyc = 1;
    for (int i = 0; i < 40 && nout < 2; i++) begin
      if (out_valid) begin
        t[nout] = cyc;
        v[nout] = plain_out;
        nout++;
      end
      if (nout == 2) in_valid = 1'b0;
      else begin
        tick();
        cyc++;
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (nout != 2) begin
      n_err++;
      $display("FAIL b2b_count: got %0d outputs required 2", nout);
    end else begin
      n_cmp++; if (v[0] !== B_PT) begin n_err++; $display("FAIL b2b_first: got %h required %h", v[0], B_PT); end
      n_cmp++; if (v[1] !== C_PT) begin n_err++; $display("FAIL b2b_second: got %h required %h", v[1], C_PT); end
      n_cmp++; if (t[1] - t[0] != 12) begin n_err++; $display("FAIL b2b_spacing: got %0d clk required 12", t[1] - t[0]); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_after: busy=%0b required 0", busy); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    build_tables();
    test_reset();
    test_fips();
    test_hold();
    test_ignore_busy();
    test_reset_mid_block();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
